// File: rtl/dvp_tx_pkg.sv
// dvp_tx_pkg: types and helpers shared by the DVP transmit and receive paths.
//   dataPort_t      - pixel stream payload {valid, data[23:0] = {r,g,b}}
//   state_t         - transmitter frame FSM states
//   bytes_per_pixel - bytes per pixel for a DATA_FORMAT string
//   pack565/unpack565 - RGB888 <-> RGB565 conversion
package dvp_tx_pkg;

  // Same layout as the shared interface header's pixel port.
  typedef struct packed {
    logic        valid;
    logic [23:0] data;
  } dataPort_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VSYNC,
    ST_VBACK,
    ST_LINE,
    ST_HBLANK,
    ST_VFRONT
  } state_t;

  function automatic int unsigned bytes_per_pixel(input string fmt);
    return (fmt == "RGB565") ? 32'd2 : 32'd3;
  endfunction

  // Truncate to 5/6/5 bits: {r[7:3], g[7:2], b[7:3]}.
  function automatic logic [15:0] pack565(input logic [23:0] rgb);
    return {rgb[23:19], rgb[15:10], rgb[7:3]};
  endfunction

  // Expand back to 8 bits per channel by replicating the channel MSBs.
  function automatic logic [23:0] unpack565(input logic [15:0] p);
    return {p[15:11], p[15:13], p[10:5], p[10:9], p[4:0], p[4:2]};
  endfunction

endpackage

// File: rtl/dvp_tx_serializer.sv
// dvp_tx_serializer: latches one pixel and emits it a byte per clock, MSB first.
//   pclk, rst_n - clock, synchronous active-low reset
//   load        - latch pixel/valid and drive its first byte next cycle
//   shift       - drive the next byte of the latched pixel
//   valid       - pixel valid; an invalid pixel is sent as all-zero bytes
//   pixel       - {r,g,b}
//   data        - registered output byte, 0x00 when neither load nor shift
module dvp_tx_serializer
  import dvp_tx_pkg::*;
#(
  parameter bit RGB565 = 1'b0
) (
  input  logic        pclk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        shift,
  input  logic        valid,
  input  logic [23:0] pixel,
  output logic [7:0]  data
);

  logic [23:0] pix_c;
  logic [23:0] shreg;

  // Byte image of the incoming pixel, left-aligned so byte 0 sits in [23:16].
  always_comb begin
    pix_c = RGB565 ? {pack565(pixel), 8'h00} : pixel;
    if (!valid) pix_c = '0;
  end

  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      shreg <= '0;
      data  <= '0;
    end else if (load) begin
      data  <= pix_c[23:16];
      shreg <= {pix_c[15:0], 8'h00};
    end else if (shift) begin
      data  <= shreg[23:16];
      shreg <= {shreg[15:0], 8'h00};
    end else begin
      data  <= '0;
      shreg <= '0;
    end
  end

endmodule

// File: rtl/dvp_tx.sv
// dvp_tx: DVP camera-port transmitter (vsync/href/8-bit data) from an RGB pixel stream.
//   pclk, rst_n - clock, synchronous active-low reset
//   enable      - start a frame from IDLE / chain another frame at end of V_FRONT
//   in          - pixel stream {valid, data}
//   inReady     - combinational; pixel taken at the coming edge
//   vsync, href - frame sync and line valid, active high
//   data        - pixel byte, 0x00 while href is low
//   busy        - any state but IDLE
//   underflow   - sticky, set when a pixel slot found in.valid low; cleared at vsync
module dvp_tx
  import dvp_tx_pkg::*;
#(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned HEIGHT      = 16,
  parameter string       DATA_FORMAT = "RGB888",
  parameter int unsigned VSYNC_LEN   = 4,
  parameter int unsigned V_BACK      = 8,
  parameter int unsigned H_BLANK     = 8,
  parameter int unsigned V_FRONT     = 8
) (
  input  logic       pclk,
  input  logic       rst_n,
  input  logic       enable,
  input  dataPort_t  in,
  output logic       inReady,
  output logic       vsync,
  output logic       href,
  output logic [7:0] data,
  output logic       busy,
  output logic       underflow
);

  localparam int unsigned BYTES     = bytes_per_pixel(DATA_FORMAT);
  localparam int unsigned M1        = (VSYNC_LEN > V_BACK) ? VSYNC_LEN : V_BACK;
  localparam int unsigned M2        = (H_BLANK > V_FRONT) ? H_BLANK : V_FRONT;
  localparam int unsigned BLANK_MAX = (M1 > M2) ? M1 : M2;
  localparam int unsigned CW        = (BLANK_MAX > 1) ? $clog2(BLANK_MAX) : 1;
  localparam int unsigned BW        = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int unsigned HW        = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned VW        = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [BW-1:0]   byte_idx, byte_nxt;
  logic [HW-1:0]   h_cnt, h_nxt;
  logic [VW-1:0]   v_cnt, v_nxt;
  logic            blank_last;

  // Next state, counters, and the pixel request one cycle ahead of each first byte.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    byte_nxt   = byte_idx;
    h_nxt      = h_cnt;
    v_nxt      = v_cnt;
    blank_last = 1'b0;
    inReady    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (enable) begin
          state_nxt = ST_VSYNC;
          cnt_nxt   = '0;
          byte_nxt  = '0;
          h_nxt     = '0;
          v_nxt     = '0;
        end
      end
      ST_VSYNC: begin
        blank_last = (cnt == CW'(VSYNC_LEN - 1));
        cnt_nxt    = blank_last ? '0 : cnt + CW'(1);
        if (blank_last) state_nxt = ST_VBACK;
      end
      ST_VBACK: begin
        blank_last = (cnt == CW'(V_BACK - 1));
        cnt_nxt    = blank_last ? '0 : cnt + CW'(1);
        inReady    = blank_last;
        if (blank_last) state_nxt = ST_LINE;
      end
      ST_LINE: begin
        if (byte_idx == BW'(BYTES - 1)) begin
          byte_nxt = '0;
          if (h_cnt == HW'(WIDTH - 1)) begin
            h_nxt     = '0;
            state_nxt = ST_HBLANK;
          end else begin
            h_nxt   = h_cnt + HW'(1);
            inReady = 1'b1;
          end
        end else begin
          byte_nxt = byte_idx + BW'(1);
        end
      end
      ST_HBLANK: begin
        blank_last = (cnt == CW'(H_BLANK - 1));
        cnt_nxt    = blank_last ? '0 : cnt + CW'(1);
        if (blank_last) begin
          if (v_cnt == VW'(HEIGHT - 1)) begin
            v_nxt     = '0;
            state_nxt = ST_VFRONT;
          end else begin
            v_nxt     = v_cnt + VW'(1);
            inReady   = 1'b1;
            state_nxt = ST_LINE;
          end
        end
      end
      ST_VFRONT: begin
        blank_last = (cnt == CW'(V_FRONT - 1));
        cnt_nxt    = blank_last ? '0 : cnt + CW'(1);
        if (blank_last) begin
          state_nxt = enable ? ST_VSYNC : ST_IDLE;
          byte_nxt  = '0;
          h_nxt     = '0;
          v_nxt     = '0;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State, counters and registered outputs all follow the next state.
  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      byte_idx  <= '0;
      h_cnt     <= '0;
      v_cnt     <= '0;
      vsync     <= 1'b0;
      href      <= 1'b0;
      busy      <= 1'b0;
      underflow <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      byte_idx <= byte_nxt;
      h_cnt    <= h_nxt;
      v_cnt    <= v_nxt;
      vsync    <= (state_nxt == ST_VSYNC);
      href     <= (state_nxt == ST_LINE);
      busy     <= (state_nxt != ST_IDLE);
      if (state_nxt == ST_VSYNC && state != ST_VSYNC) underflow <= 1'b0;
      else if (inReady && !in.valid)                 underflow <= 1'b1;
    end
  end

  // A missing pixel still consumes its slot; it is sent as zero bytes.
  dvp_tx_serializer #(
    .RGB565 (BYTES == 2)
  ) u_ser (
    .pclk  (pclk),
    .rst_n (rst_n),
    .load  (inReady),
    .shift (state_nxt == ST_LINE),
    .valid (in.valid),
    .pixel (in.data),
    .data  (data)
  );

endmodule

// File: tb/tb_dvp_tx.sv
`timescale 1ns/1ps
module tb_dvp_tx;
  import dvp_tx_pkg::*;

  localparam int W = 4, H = 2, VL = 4, VB = 8, HB = 8, VF = 8;
  localparam int DROP_IDX = 6;   // line 1, pixel 2

  logic pclk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  always #5 pclk = ~pclk;

  dataPort_t in0 = '0, in1 = '0;
  logic rdy0, rdy1, vs0, vs1, hr0, hr1, bz0, bz1, uf0, uf1;
  logic [7:0] d0, d1;

  dvp_tx #(.WIDTH(W), .HEIGHT(H), .DATA_FORMAT("RGB888"), .VSYNC_LEN(VL),
           .V_BACK(VB), .H_BLANK(HB), .V_FRONT(VF)) dut0 (
    .pclk(pclk), .rst_n(rst_n), .enable(enable), .in(in0), .inReady(rdy0),
    .vsync(vs0), .href(hr0), .data(d0), .busy(bz0), .underflow(uf0));

  dvp_tx #(.WIDTH(W), .HEIGHT(H), .DATA_FORMAT("RGB565"), .VSYNC_LEN(VL),
           .V_BACK(VB), .H_BLANK(HB), .V_FRONT(VF)) dut1 (
    .pclk(pclk), .rst_n(rst_n), .enable(enable), .in(in1), .inReady(rdy1),
    .vsync(vs1), .href(hr1), .data(d1), .busy(bz1), .underflow(uf1));

  int n_chk = 0, n_fail = 0;
  int drop_fn = 0;
  bit done = 1'b0, timed_out = 1'b0;

  // ---------------- reference model helpers ----------------
  function automatic int bpp(input int i); return (i == 0) ? 3 : 2; endfunction
  function automatic int wb(input int i); return W * bpp(i); endfunction
  function automatic int period(input int i); return VL + VB + H * (wb(i) + HB) + VF; endfunction
  function automatic int drop_rel(input int i);
    return (DROP_IDX / W) * (wb(i) + HB) + (DROP_IDX % W) * bpp(i);
  endfunction

  function automatic logic [23:0] gen_px(input int i, input int k);
    if (i == 0 && k < 4) return 24'h112233 + 24'h333333 * 24'(k);
    if (i == 1 && k == 0) return 24'hFF8040;
    return 24'($urandom);
  endfunction

  function automatic bit is_drop(input int k);
    return (k / (W * H)) == drop_fn && (k % (W * H)) == DROP_IDX;
  endfunction

  // ---------------- stimulus: pixel feeder / scoreboard producer ----------------
  logic [7:0] q0[$], q1[$];
  int base[2] = '{0, 0};
  logic [23:0] cur_px[2];
  bit cur_v[2] = '{0, 0};
  int k_px[2] = '{0, 0};
  bit took[2] = '{0, 0};

  task automatic push_px(input int i, input logic [23:0] p, input bit v);
    int r, g, b, hi, lo;
    r = int'(p[23:16]); g = int'(p[15:8]); b = int'(p[7:0]);
    if (i == 0) begin
      q0.push_back(v ? 8'(r) : 8'h00);
      q0.push_back(v ? 8'(g) : 8'h00);
      q0.push_back(v ? 8'(b) : 8'h00);
    end else begin
      hi = (r / 8) * 8 + g / 32;
      lo = ((g / 4) % 8) * 32 + b / 8;
      q1.push_back(v ? 8'(hi) : 8'h00);
      q1.push_back(v ? 8'(lo) : 8'h00);
    end
  endtask

  always @(posedge pclk) begin
    #1;
    for (int i = 0; i < 2; i++) begin
      logic r;
      r = (i == 0) ? rdy0 : rdy1;
      if (!rst_n) begin
        k_px[i] = 0;
        took[i] = 1'b0;
        base[i] = (i == 0) ? q0.size() : q1.size();
      end else if (took[i]) begin
        k_px[i] = k_px[i] + 1;
      end
      if (!rst_n || took[i]) begin
        cur_px[i] = gen_px(i, k_px[i]);
        cur_v[i]  = !is_drop(k_px[i]);
      end
      took[i] = rst_n && r;
      if (took[i]) push_px(i, cur_px[i], cur_v[i]);
    end
    in0.valid = cur_v[0]; in0.data = cur_px[0];
    in1.valid = cur_v[1]; in1.data = cur_px[1];
  end

  // ---------------- monitor / checker ----------------
  bit run[2] = '{0, 0};
  int f[2] = '{0, 0};
  int fn[2] = '{-1, -1};
  bit ufm[2] = '{0, 0};
  int rd[2] = '{0, 0};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic mon(input int i, input logic vs, input logic hr, input logic bz,
                     input logic uf, input logic [7:0] d);
    bit evs, ehr;
    int rel, sz;
    logic [7:0] eb;
    evs = 1'b0; ehr = 1'b0;
    if (run[i]) begin
      evs = f[i] < VL;
      rel = f[i] - VL - VB;
      ehr = rel >= 0 && rel < H * (wb(i) + HB) && (rel % (wb(i) + HB)) < wb(i);
    end
    check($sformatf("vsync%0d", i), 32'(vs), 32'(evs));
    check($sformatf("href%0d", i), 32'(hr), 32'(ehr));
    check($sformatf("busy%0d", i), 32'(bz), 32'(run[i]));
    check($sformatf("underflow%0d", i), 32'(uf), 32'(ufm[i]));
    if (rd[i] < base[i]) rd[i] = base[i];
    if (ehr) begin
      sz = (i == 0) ? q0.size() : q1.size();
      if (rd[i] >= sz) check($sformatf("byte_avail%0d", i), 32'(0), 32'(1));
      else begin
        eb = (i == 0) ? q0[rd[i]] : q1[rd[i]];
        rd[i] = rd[i] + 1;
        check($sformatf("data%0d", i), 32'(d), 32'(eb));
      end
    end else begin
      check($sformatf("data_idle%0d", i), 32'(d), 32'(0));
    end
    // advance the frame-position model to the next cycle
    if (!rst_n) begin
      run[i] = 1'b0; fn[i] = -1; ufm[i] = 1'b0;
    end else if (!run[i]) begin
      if (enable) begin run[i] = 1'b1; f[i] = 0; fn[i]++; ufm[i] = 1'b0; end
    end else begin
      f[i]++;
      if (f[i] == period(i)) begin
        if (enable) begin f[i] = 0; fn[i]++; ufm[i] = 1'b0; end
        else run[i] = 1'b0;
      end else if (fn[i] == drop_fn && f[i] - VL - VB == drop_rel(i)) begin
        ufm[i] = 1'b1;
      end
    end
  endtask

  always @(negedge pclk) begin
    mon(0, vs0, hr0, bz0, uf0, d0);
    mon(1, vs1, hr1, bz1, uf1, d1);
    if (done) begin
      check("unpack565", 32'(unpack565(16'hFC08)), 32'h00FF8242);
      check("href_wait", 32'(timed_out), 32'(0));
      check("q0_drained", 32'(rd[0]), 32'(q0.size()));
      check("q1_drained", 32'(rd[1]), 32'(q1.size()));
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
    end
  end

  // ---------------- sequencer ----------------
  task automatic step(input int n);
    repeat (n) @(posedge pclk);
    #2;
  endtask

  initial begin
    step(3);
    rst_n = 1'b1;
    step(2);
    // continuous frames, then enable dropped mid-frame
    enable = 1'b1;
    step(100);
    enable = 1'b0;
    step(80);
    // single-cycle enable pulse
    enable = 1'b1;
    step(1);
    enable = 1'b0;
    step(80);
    // reset in the middle of a line, then restart
    enable = 1'b1;
    for (int c = 0; c < 200 && !hr0; c++) step(1);
    if (!hr0) timed_out = 1'b1;
    step(3);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    step(30);
    enable = 1'b0;
    step(80);
    done = 1'b1;
  end

endmodule
